// File: rtl/run_count_scheduler_pkg.sv
// Shared types for the run-count scheduler: FSM state encoding and a width helper.
package run_count_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_REPORT  = 3'd4
  } state_t;

  // Bits needed to hold values 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/run_count_scheduler_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module run_count_scheduler_rr_arbiter
  import run_count_scheduler_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]        req,
  input  logic [clog2(N_CH)-1:0] ptr,
  input  logic                   en,
  output logic [N_CH-1:0]        gnt,
  output logic [clog2(N_CH)-1:0] idx
);

  localparam int IW = clog2(N_CH);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    if (en) begin
      // Scan from farthest to nearest so the last hit is the nearest to ptr.
      for (int i = N_CH - 1; i >= 0; i--) begin
        j = int'(ptr) + i;
        if (j >= N_CH) j = j - N_CH;
        if (req[IW'(j)]) begin
          gnt           = '0;
          gnt[IW'(j)]   = 1'b1;
          idx           = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/run_count_scheduler.sv
// Time-shares one external consecutive-ones run counter between N_CH serial channels,
// returning each window's count with its channel id over a valid/ready port.
module run_count_scheduler
  import run_count_scheduler_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CW        = 8,
  parameter int WLW       = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH-1:0]        din_bus,
  input  logic [WLW-1:0]         window_len,
  output logic                   cnt_rst,
  output logic                   cnt_din,
  input  logic [CW-1:0]          cnt_count,
  output logic [N_CH-1:0]        grant,
  output logic                   busy,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CW-1:0]          res_count,
  output logic [clog2(N_CH)-1:0] res_chan,
  output state_t                 dbg_state
);

  localparam int IW = clog2(N_CH);
  localparam int DW = clog2(DRAIN_CYC + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   chan;
  logic [WLW-1:0]  wcnt;
  logic [DW-1:0]   dcnt;
  logic [WLW-1:0]  w_eff;
  logic [IW-1:0]   next_ptr;
  logic [N_CH-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;
  logic            arb_en;

  assign w_eff    = (window_len == '0) ? WLW'(1) : window_len;
  assign next_ptr = (chan == IW'(N_CH - 1)) ? '0 : chan + IW'(1);
  assign arb_en   = (state == ST_IDLE) && !res_valid;

  run_count_scheduler_rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req (req),
    .ptr (ptr),
    .en  (arb_en),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign cnt_rst   = rst || (state == ST_CLEAR);
  assign cnt_din   = !rst && (state == ST_MEASURE) && din_bus[chan];
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Result port: res_valid rises on entry to REPORT and holds, with res_count/res_chan
  // stable, until a cycle where res_valid && res_ready; that edge is the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      grant     <= '0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_chan  <= '0;
      ptr       <= '0;
      chan      <= '0;
      wcnt      <= '0;
      dcnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_en && (|req)) begin
            grant <= arb_gnt;
            chan  <= arb_idx;
            wcnt  <= w_eff;
            state <= ST_CLEAR;
          end
        end
        ST_CLEAR: state <= ST_MEASURE;
        ST_MEASURE: begin
          if (wcnt == WLW'(1)) begin
            wcnt  <= '0;
            dcnt  <= DW'(DRAIN_CYC);
            state <= ST_DRAIN;
          end else begin
            wcnt <= wcnt - WLW'(1);
          end
        end
        ST_DRAIN: begin
          if (dcnt == DW'(1)) begin
            dcnt      <= '0;
            res_count <= cnt_count;
            res_chan  <= chan;
            res_valid <= 1'b1;
            state     <= ST_REPORT;
          end else begin
            dcnt <= dcnt - DW'(1);
          end
        end
        ST_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            grant     <= '0;
            ptr       <= next_ptr;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_count_scheduler.sv
// Directed bench for run_count_scheduler with a behavioural consecutive-ones run counter.
module tb_run_count_scheduler;
  import run_count_scheduler_pkg::*;

  localparam int N_CH      = 4;
  localparam int CW        = 8;
  localparam int WLW       = 16;
  localparam int DRAIN_CYC = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] req = '0;
  logic [N_CH-1:0] din_bus = '0;
  logic [WLW-1:0]  window_len = '0;
  logic            cnt_rst;
  logic            cnt_din;
  logic [CW-1:0]   cnt_count;
  logic [N_CH-1:0] grant;
  logic            busy;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [CW-1:0]   res_count;
  logic [1:0]      res_chan;
  state_t          dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  run_count_scheduler #(
    .N_CH(N_CH), .CW(CW), .WLW(WLW), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din_bus    (din_bus),
    .window_len (window_len),
    .cnt_rst    (cnt_rst),
    .cnt_din    (cnt_din),
    .cnt_count  (cnt_count),
    .grant      (grant),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_count  (res_count),
    .res_chan   (res_chan),
    .dbg_state  (dbg_state)
  );

  // Shared counter: counts 0->1 transitions of its serial input, one-cycle latency.
  logic [CW-1:0] oc_count = '0;
  logic          oc_prev  = 1'b0;
  assign cnt_count = oc_count;

  always @(posedge clk) begin
    if (cnt_rst) begin
      oc_count <= '0;
      oc_prev  <= 1'b0;
    end else begin
      oc_prev <= cnt_din;
      if (cnt_din && !oc_prev) oc_count <= oc_count + CW'(1);
    end
  end

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (grant == '0 && waited < 20) begin
      tick();
      waited++;
    end
  endtask

  // One full grant-to-handshake transaction. pat bit k feeds MEASURE cycle k on the
  // granted channel; other channels carry the complement to expose a wrong mux select.
  task automatic run_one(input int ch, input int wl, input logic [15:0] pat,
                         input logic [7:0] exp_count, input int bp, input bit drop);
    int              waited;
    int              n;
    int              ones;
    int              ones_exp;
    int              w;
    logic [N_CH-1:0] d;
    logic [N_CH-1:0] g_exp;
    logic            b;
    w          = (wl == 0) ? 1 : wl;
    window_len = WLW'(wl);
    g_exp      = N_CH'(1 << ch);
    wait_grant(waited);
    check("grant_wait", waited, 1);
    check("grant", 32'(grant), 32'(g_exp));
    check("clear_cnt_rst", 32'(cnt_rst), 1);
    if (drop) req = '0;
    ones     = 0;
    ones_exp = 0;
    for (int k = 0; k < w; k++) if (pat[4'(k)]) ones_exp++;
    n = 0;
    while (!res_valid && n < 100) begin
      if (n >= 1 && n <= w) begin
        b = pat[4'(n - 1)];
        d = {N_CH{~b}};
        d[2'(ch)] = b;
      end else begin
        d = '1;
      end
      din_bus = d;
      #1;
      if (cnt_din) ones++;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 1 + w + DRAIN_CYC);
    check("measure_ones", ones, ones_exp);
    check("res_count", 32'(res_count), 32'(exp_count));
    check("res_chan", 32'(res_chan), ch);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_valid", 32'(res_valid), 1);
      check("bp_count", 32'(res_count), 32'(exp_count));
      check("bp_chan", 32'(res_chan), ch);
      check("bp_grant", 32'(grant), 32'(g_exp));
      check("bp_no_clear", 32'(cnt_rst), 0);
    end
    res_ready = 1'b1;
    tick();
    check("hs_valid", 32'(res_valid), 0);
    check("hs_busy", 32'(busy), 0);
    check("hs_grant", 32'(grant), 0);
    din_bus = '0;
  endtask

  initial begin
    int waited;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_cnt_rst", 32'(cnt_rst), 1);
    check("rst_cnt_din", 32'(cnt_din), 0);
    rst = 1'b0;
    #1;
    check("idle_cnt_rst", 32'(cnt_rst), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant), 0);
    check("rst_valid", 32'(res_valid), 0);
    check("rst_count", 32'(res_count), 0);
    check("rst_chan", 32'(res_chan), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // round robin from ptr=0 with req held: 0,1,3,0
    res_ready = 1'b1;
    req = 4'b1011;
    run_one(0, 3, 16'h0005, 8'd2, 0, 1'b0);
    run_one(1, 3, 16'h0007, 8'd1, 0, 1'b0);
    run_one(3, 3, 16'h0002, 8'd1, 0, 1'b0);
    run_one(0, 3, 16'h0000, 8'd0, 0, 1'b0);

    // single channel, din 1,1,0,1,0,0,1,1 -> 3 runs
    req = 4'b0010;
    run_one(1, 8, 16'h00CB, 8'd3, 0, 1'b0);

    // backpressure: ptr=2, channel 3 waits while channel 2 is reported
    req = 4'b1100;
    res_ready = 1'b0;
    run_one(2, 4, 16'h0006, 8'd1, 5, 1'b0);

    // window_len=0 acts as a one-cycle window
    req = 4'b0010;
    run_one(1, 0, 16'hFFFF, 8'd1, 0, 1'b0);

    // drop req right after grant; then wrap from ptr=3 to channel 0
    req = 4'b0100;
    run_one(2, 5, 16'h0000, 8'd0, 0, 1'b1);
    req = 4'b0011;
    run_one(0, 2, 16'h0001, 8'd1, 0, 1'b0);

    // reset in MEASURE cycle 3 of W=8
    req = 4'b0100;
    window_len = 16'd8;
    wait_grant(waited);
    check("mid_grant", 32'(grant), 32'(4'b0100));
    tick();
    tick();
    tick();
    din_bus = '1;
    rst = 1'b1;
    #1;
    check("mid_cnt_rst", 32'(cnt_rst), 1);
    check("mid_cnt_din", 32'(cnt_din), 0);
    @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_grant_clr", 32'(grant), 0);
    check("mid_valid", 32'(res_valid), 0);
    check("mid_count", 32'(res_count), 0);
    rst = 1'b0;
    din_bus = '0;
    req = 4'b1111;
    run_one(0, 2, 16'h0003, 8'd1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
